// File: rtl/output_pulse_driver_pkg.sv
// ----------------------------------------------------------------------------
// output_pkg
// Shared types and default timing constants for output_pulse_driver.
// The default HOLD/GAP constants are also used by top-level pin assignments
// so every pulsed pin on the board uses the same timing unless overridden.
// ----------------------------------------------------------------------------
package output_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2
    } pulse_state_t;

    localparam int DEFAULT_HOLD_CYCLES = 4;
    localparam int DEFAULT_GAP_CYCLES  = 2;

    // Larger of two ints; used to size the shared hold/gap counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/output_pulse_driver_if.sv
// ----------------------------------------------------------------------------
// output_pulse_driver_if
// Bundles the request/pin/status signals of one pulsed output.
//   in      : request level from core logic (0->1 = one request)
//   out     : registered pin drive
//   busy    : driver is not idle
//   dropped : sticky, a request was lost
// master : core-logic side (drives in, observes the rest)
// slave  : the pulse driver itself
// ----------------------------------------------------------------------------
interface output_pulse_driver_if;
    logic in;
    logic out;
    logic busy;
    logic dropped;

    modport master (output in, input out, input busy, input dropped);
    modport slave  (input in, output out, output busy, output dropped);
endinterface

// File: rtl/output_pulse_driver_rise_detect.sv
// ----------------------------------------------------------------------------
// rise_detect
// Turns a synchronous level into a one-cycle request on each 0->1 transition.
// prev resets to 1 so a level already high when reset releases is ignored.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   level : synchronous request level
//   trig  : combinational, level & ~prev
// ----------------------------------------------------------------------------
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic trig
);

    logic prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign trig = level & ~prev_q;

endmodule

// File: rtl/output_pulse_driver.sv
// ----------------------------------------------------------------------------
// output_pulse_driver
// Registered output stage for one pin. Each rising edge of bus.in becomes a
// pulse of exactly HOLD_CYCLES cycles followed by at least GAP_CYCLES inactive
// cycles. One request arriving during a pulse/gap is queued; a further one is
// lost and flagged on the sticky dropped output.
//
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : output_pulse_driver_if.slave (in, out, busy, dropped)
//
// Build option: define OUTPUT_ACTIVE_LOW_EN for active-low pads (out idles 1,
// pulses 0). The inversion sits at the flop D input, so out is always a
// direct flop output.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no pulse, waiting for a request
// ACTIVE | out at active level, counting HOLD_CYCLES
// GAP    | out inactive, enforcing GAP_CYCLES before the next pulse
// ----------------------------------------------------------------------------
module output_pulse_driver
    import output_pkg::*;
#(
    parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
    parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
    parameter int CNT_W       = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES) + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    output_pulse_driver_if.slave  bus
);

    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("output_pulse_driver: HOLD_CYCLES must be >= 1");
    end
    if (GAP_CYCLES < 0) begin : g_bad_gap
        $error("output_pulse_driver: GAP_CYCLES must be >= 0");
    end

`ifdef OUTPUT_ACTIVE_LOW_EN
    localparam logic ACT_LVL = 1'b0;
`else
    localparam logic ACT_LVL = 1'b1;
`endif

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  =
        (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    pulse_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic             dropped_q, dropped_d;
    logic             out_q;
    logic             active_d;
    logic             queue_trig;
    logic             trig;

    rise_detect u_rise_detect (
        .clk   (clk),
        .reset (reset),
        .level (bus.in),
        .trig  (trig)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            dropped_q <= 1'b0;
            out_q     <= ~ACT_LVL;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
            out_q     <= active_d ? ACT_LVL : ~ACT_LVL;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        dropped_d  = dropped_q;
        active_d   = 1'b0;
        queue_trig = 1'b0;

        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d  = ACTIVE;
                    cnt_d    = HOLD_LOAD;
                    active_d = 1'b1;
                end
            end

            ACTIVE: begin
                active_d = 1'b1;
                if (cnt_q != '0) begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    queue_trig = 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_d    = GAP;
                    cnt_d      = GAP_LOAD;
                    active_d   = 1'b0;
                    queue_trig = 1'b1;
                end else if (pending_q || trig) begin
                    // Zero-gap restart: the queued request is served first,
                    // a coincident trig takes its place in the queue.
                    cnt_d     = HOLD_LOAD;
                    pending_d = pending_q & trig;
                end else begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                end
            end

            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d      = cnt_q - CNT_W'(1);
                    queue_trig = 1'b1;
                end else if (pending_q || trig) begin
                    state_d   = ACTIVE;
                    cnt_d     = HOLD_LOAD;
                    active_d  = 1'b1;
                    pending_d = pending_q & trig;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                cnt_d     = '0;
                pending_d = 1'b0;
            end
        endcase

        // A request not consumed by a transition on this edge is queued;
        // with the single slot already full it is lost.
        if (queue_trig && trig) begin
            if (pending_q) begin
                dropped_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.busy    = (state_q != IDLE);
    assign bus.dropped = dropped_q;

endmodule

// File: doc/output_pulse_driver.md
Name: output_pulse_driver

Overview:
- Registered output stage for one FPGA output pin (LED, buzzer, handshake line to the external board). It is the outbound counterpart of the input synchronizer stage.
- Converts a synchronous request edge from core logic into a glitch-free pin pulse with a guaranteed minimum high width and minimum low gap.
- Queues one request that arrives while a pulse is in progress.
- Pin output comes straight from a flop, with no combinational path to the pad.

Parameters:
- HOLD_CYCLES, 4: clock cycles the output is held active per pulse; must be >= 1.
- GAP_CYCLES, 2: minimum inactive cycles after each pulse before the next one; 0 allowed.
- CNT_W, $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1): counter width, derived; do not override.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- in  in  1  request level from core logic, synchronous to clk; a 0->1 transition is one request.
- out  out  1  registered pin drive.
- busy  out  1  high while the state is not IDLE.
- dropped  out  1  sticky: a request was lost; cleared only by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, pending=0, dropped=0, busy=0.
  - out=inactive level (0; see Optional Feature).
  - prev_in=1, so an input already high at reset release does not create a request.
- Request detect: trig = in & ~prev_in, evaluated combinationally. prev_in <= in every edge. Each rising edge of in yields exactly one request, however long in stays high.
- IDLE: on an edge with trig=1 -> ACTIVE, counter=HOLD_CYCLES-1, out=1. Out is visible high in the cycle after that edge, giving 1-cycle latency.
- ACTIVE:
  - Out stays 1; counter decrements each edge.
  - When counter==0: if GAP_CYCLES>0, go to GAP with counter=GAP_CYCLES-1 and out=0.
  - If GAP_CYCLES==0: go to ACTIVE (restart) if pending|trig, else IDLE with out=0.
  - Out is therefore high for exactly HOLD_CYCLES cycles.
- GAP:
  - Out=0; counter decrements each edge.
  - When counter==0: go to ACTIVE if pending|trig (out=1, pending cleared), else IDLE.
- Pending queue (one deep):
  - trig in ACTIVE or GAP, not consumed by a transition on that same edge, sets pending.
  - trig while pending is already 1 sets dropped=1; pending stays 1.
- Simultaneous events: a trig on the edge that ends ACTIVE (GAP_CYCLES=0) or ends GAP is consumed directly. It does not set pending and is not counted as dropped.
- Back-to-back pulses: no glitch on out; out rises exactly GAP_CYCLES cycles after it fell.
- Reset mid-pulse: out goes inactive immediately and asynchronously; the pending request is discarded.
- State encoding: IDLE, ACTIVE, GAP as a 2-bit enum; the illegal code recovers to IDLE with out inactive.

Optional Feature:
- Macro OUTPUT_ACTIVE_LOW_EN.
- Defined: out is driven inverted. Reset/inactive value is 1 and the active pulse is 0, for active-low pads. The inversion is applied at the flop D input, so out remains a direct flop output.
- Undefined: active-high, reset value 0.
- busy and dropped are unaffected either way.

Decomposition:
- Package output_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACTIVE, GAP} pulse_state_t;
  - the default HOLD/GAP constants, shared with top-level pin assignments.
- One natural sub-module, rise_detect: holds prev_in (reset value 1) and produces trig. It is reusable for other request inputs.

Test Plan:
- Single request (HOLD=4, GAP=2): in 0->1 at edge 5, held high 20 cycles -> out high for cycles after edges 5..8, low at edge 9; busy high through edge 10; exactly one pulse; dropped=0.
- Queued request: second rising edge of in during ACTIVE (edge 7) -> pending=1; out falls at edge 9, rises again at edge 11, high 4 cycles; dropped=0.
- Overflow: three rising edges of in during one ACTIVE/GAP window -> two pulses total, dropped=1 and stays 1 until reset.
- Edge-coincident trigger: in rises on the edge GAP expires (edge 11 after a pulse at 5) -> pulse starts at edge 11 with no IDLE cycle; pending never set.
- Reset mid-pulse: reset low at edge 7 mid-ACTIVE, asynchronously between edges -> out drops immediately, busy=0. Release reset with in held high -> no pulse until in goes 0 then 1.
- GAP_CYCLES=0 and OUTPUT_ACTIVE_LOW_EN variants:
  - GAP=0 with a queued request -> out stays active for 8 contiguous cycles.
  - Active-low build -> out resets to 1 and pulses 0 for 4 cycles.
